adder_seq_sched: RTL and testbench
==================================

# adder_seq_sched

Multi-cycle WIDTH-bit adder controller that time-shares one external 2-bit adder slice between two requesters. It arbitrates round-robin, latches the granted operands, and drives the slice two bits per cycle, LSB pair first, rippling the carry through an internal register. It returns the full sum and carry-out with a one-cycle acknowledge. The block sits between the two requesting units and the existing 2-bit slice, which is connected at top level.

## Interface
- WIDTH, 8, operand width; must be even and ≥2.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset, synchronous, active-low.
- Req0, Req1  input  1 each  request from requester 0 / 1.
- A_In0, B_In0, A_In1, B_In1  input  WIDTH each  operands; held stable while Req is high.
- Cin_In0, Cin_In1  input  1 each  carry-in per requester.
- Ack0, Ack1  output  1 each  one-cycle result-valid pulse to requester 0 / 1.
- Sum  output  WIDTH  result of the last completed operation.
- Cout  output  1  carry-out of the last completed operation.
- Busy  output  1  high in RUN and DONE.
- Gnt_Id  output  1  requester of the current or last operation.
- A0, B0, A1, B1, Cin  output  1 each  drive the 2-bit slice inputs.
- S0, S1, Cout_Slice  input  1 each  slice sum bits and carry-out.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - If any Req is high at a clock edge, grant one requester.
  - Load the granted A, B and Cin into the operand shift registers and the carry register.
  - Clear the pair counter. Go to RUN.
- **Arbitration:** round-robin via Last_Gnt.
  - Single requester: it is granted.
  - Both requesting: grant the requester that is not Last_Gnt.
  - Last_Gnt updates on each grant.
- **RUN:**
  - Slice inputs are combinational from registers: A0/A1 = low 2 bits of A shift reg, B0/B1 likewise, Cin = carry reg.
  - Each edge:
    - Shift {S1,S0} into the sum shift register from the top (shift right by 2).
    - Carry reg <= Cout_Slice.
    - Shift both operand registers right by 2.
    - Increment the pair counter.
  - After WIDTH/2 captures, go to DONE.
- **DONE:**
  - Sum = sum shift register; Cout = carry reg.
  - Ack of the granted requester = 1 for exactly this cycle.
  - Next edge: go to IDLE.
- Outside RUN: A0, B0, A1, B1 and Cin are driven 0.
- Sum, Cout and Gnt_Id hold their values until the next DONE or grant.
- Requesters drop Req in the cycle after Ack. A Req still high in IDLE counts as a new request.
- Req changes during RUN/DONE are ignored. Operands are sampled only at grant.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB pair is Cout.

## Timing
- **Reset values** (Rst_n low at an edge):
  - Next state IDLE.
  - Ack0, Ack1, Busy, Sum, Cout, Gnt_Id, slice drives and pair counter all 0.
  - Last_Gnt = 1, so requester 0 wins the first tie.
- **Reset is synchronous.** Reset mid-RUN or in DONE aborts the operation: no Ack is issued and the result is discarded.
- **Latency:** the Req is sampled at edge E. Ack is high in the cycle following edge E + WIDTH/2 + 1. For WIDTH=8, Ack rises 5 edges after the sampling edge.
- **Throughput:** back-to-back grants are possible, since the next grant occurs at the edge leaving DONE→IDLE plus one. Period is WIDTH/2 + 2 cycles per operation.
- **Slice path:** the slice is purely combinational. S0, S1 and Cout_Slice must settle within the same cycle they are driven.

## Test plan
- **Reset:**
  - Stimulus: hold Rst_n low 2 cycles with Req0=1.
  - Required: all outputs 0, no Ack.
  - After release, requester 0 is granted and Busy rises one edge later.
- **Single op:**
  - Stimulus: Req0 with A_In0=8'hA5, B_In0=8'h3C, Cin_In0=0.
  - Required: Ack0 pulses 5 edges after sampling, Sum=8'hE1, Cout=0, Gnt_Id=0.
  - Sum and Cout hold afterwards.
- **Carry ripple:**
  - Stimulus: Req1 with A=8'hFF, B=8'h00, Cin=1.
  - Required: slice Cin=1 on all 4 RUN cycles, Sum=8'h00, Cout=1, Ack1 only.
- **Contention:**
  - Stimulus: Req0 and Req1 both high after reset. Requester 1 has A=8'h80, B=8'h80, Cin=1.
  - Required: grant 0 first, then 1; requester 1's result is Sum=8'h01, Cout=1.
  - With both held high continuously, grants alternate 0,1,0,1 with a 6-cycle period.
- **Abort:**
  - Stimulus: Rst_n low during the 2nd RUN cycle.
  - Required: no Ack, outputs 0 next cycle.
  - Re-issuing A=8'h12, B=8'h34 yields Sum=8'h46, Cout=0.
- **Random:**
  - Stimulus: 256 random operand/Cin vectors on alternating requesters.
  - Required: {Cout,Sum} equals A+B+Cin for each; exactly one Ack per request; no Ack on the wrong port.

Source files
------------

// File: rtl/adder_seq_sched.sv
// Multi-cycle WIDTH-bit adder that shares one external 2-bit adder slice between
// two round-robin requesters, rippling the carry through a register, LSB pair first.
module adder_seq_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a_in0,
  input  logic [WIDTH-1:0] b_in0,
  input  logic [WIDTH-1:0] a_in1,
  input  logic [WIDTH-1:0] b_in1,
  input  logic             cin_in0,
  input  logic             cin_in1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             gnt_id,
  output logic             a0,
  output logic             b0,
  output logic             a1,
  output logic             b1,
  output logic             cin,
  input  logic             s0,
  input  logic             s1,
  input  logic             cout_slice
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = $clog2(PAIRS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH+1:0] sum_cat;
  logic             carry;
  logic [CW-1:0]    pair_cnt;
  logic             last_gnt;
  logic             grant_valid;
  logic             grant_id;

  // On a tie the requester that did not win last time gets the slice.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = 1'b0;
    if (req0 && req1) begin
      grant_id = ~last_gnt;
    end else if (req1) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_valid) state_nxt = RUN;
      RUN:  if (pair_cnt == CW'(PAIRS - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign a0   = (state == RUN) & a_sr[0];
  assign a1   = (state == RUN) & a_sr[1];
  assign b0   = (state == RUN) & b_sr[0];
  assign b1   = (state == RUN) & b_sr[1];
  assign cin  = (state == RUN) & carry;

  // New slice sum pair enters from the top so the first (LSB) pair ends up at bit 0.
  assign sum_cat = {s1, s0, sum_sr};

  // Results are published on the edge leaving DONE, so a reset landing on that
  // edge still discards the operation and suppresses the acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      pair_cnt <= '0;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      state <= state_nxt;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            a_sr     <= grant_id ? a_in1 : a_in0;
            b_sr     <= grant_id ? b_in1 : b_in0;
            carry    <= grant_id ? cin_in1 : cin_in0;
            pair_cnt <= '0;
            gnt_id   <= grant_id;
            last_gnt <= grant_id;
          end
        end
        RUN: begin
          sum_sr   <= sum_cat[WIDTH+1:2];
          carry    <= cout_slice;
          a_sr     <= a_sr >> 2;
          b_sr     <= b_sr >> 2;
          pair_cnt <= pair_cnt + CW'(1);
        end
        DONE: begin
          sum  <= sum_sr;
          cout <= carry;
          ack0 <= ~gnt_id;
          ack1 <= gnt_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_sched.sv
// Randomised self-checking bench for adder_seq_sched with a behavioural 2-bit slice
// and an arithmetic/round-robin reference model.
module tb_adder_seq_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a_in0, b_in0, a_in1, b_in1;
  logic       cin_in0, cin_in1;
  logic       ack0, ack1;
  logic [7:0] sum;
  logic       cout, busy, gnt_id;
  logic       a0, b0, a1, b1, cin;
  logic       s0, s1, cout_slice;

  int check_count = 0;
  int error_count = 0;
  int ack_seen0 = 0;
  int ack_seen1 = 0;
  int exp_acks0 = 0;
  int exp_acks1 = 0;
  bit model_last_gnt = 1'b1;

  adder_seq_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a_in0(a_in0), .b_in0(b_in0), .a_in1(a_in1), .b_in1(b_in1),
    .cin_in0(cin_in0), .cin_in1(cin_in1),
    .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout), .busy(busy), .gnt_id(gnt_id),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin(cin),
    .s0(s0), .s1(s1), .cout_slice(cout_slice)
  );

  always #5 clk = ~clk;

  // Purely combinational 2-bit slice standing in for the one wired at top level.
  assign {cout_slice, s1, s0} = {1'b0, a1, a0} + {1'b0, b1, b0} + {2'b00, cin};

  always @(negedge clk) begin
    ack_seen0 <= ack_seen0 + int'(ack0);
    ack_seen1 <= ack_seen1 + int'(ack1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic [7:0] a, input logic [7:0] b, input bit c);
    if (id) begin
      req1 = 1'b1; a_in1 = a; b_in1 = b; cin_in1 = c;
    end else begin
      req0 = 1'b1; a_in0 = a; b_in0 = b; cin_in0 = c;
    end
  endtask

  // One isolated request: grant, latency, result, pulse width and hold behaviour.
  task automatic doOp(input bit id, input logic [7:0] a, input logic [7:0] b, input bit c,
                      input bit check_ripple);
    logic [8:0] exp_res;
    int         lat;
    bit         ripple;
    exp_res = 9'(a) + 9'(b) + 9'(c);
    applyStimulus(id, a, b, c);
    @(posedge clk);
    model_last_gnt = id;
    @(negedge clk);
    checkOutput("busy_after_grant", busy, 1);
    checkOutput("gnt_id", gnt_id, id);
    ripple = 1'b1;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4) ripple = ripple & cin;
      if (ack0 | ack1) begin
        lat = k;
        break;
      end
    end
    checkOutput("ack_latency", lat, 5);
    checkOutput("ack_port", {ack1, ack0}, id ? 2'b10 : 2'b01);
    checkOutput("sum", sum, exp_res[7:0]);
    checkOutput("cout", cout, exp_res[8]);
    if (check_ripple) checkOutput("ripple_cin", ripple, 1);
    if (id) exp_acks1++; else exp_acks0++;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("ack_one_cycle", {ack1, ack0}, 2'b00);
    checkOutput("sum_hold", sum, exp_res[7:0]);
    checkOutput("cout_hold", cout, exp_res[8]);
    checkOutput("slice_idle", {a0, b0, a1, b1, cin}, 5'b0);
  endtask

  initial begin
    logic [8:0] exp0, exp1, exp_res;
    int         n;
    bit         pred;
    int         snap0, snap1;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a_in0 = '0; b_in0 = '0; a_in1 = '0; b_in1 = '0;
    cin_in0 = 1'b0; cin_in1 = 1'b0;

    // Reset held with a pending request, then the first operation.
    applyStimulus(0, 8'hA5, 8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", {ack1, ack0}, 2'b00);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_gnt_id", gnt_id, 0);
    checkOutput("rst_slice", {a0, b0, a1, b1, cin}, 5'b0);
    rst_n = 1'b1;
    doOp(0, 8'hA5, 8'h3C, 1'b0, 1'b0);

    doOp(1, 8'hFF, 8'h00, 1'b1, 1'b1);

    // Both requesters held high: grants alternate every WIDTH/2+2 cycles.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last_gnt = 1'b1;
    applyStimulus(0, 8'h5A, 8'h0F, 1'b0);
    applyStimulus(1, 8'h80, 8'h80, 1'b1);
    exp0 = 9'h05A + 9'h00F;
    exp1 = 9'h080 + 9'h080 + 9'h001;
    @(posedge clk);
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        pred = ~model_last_gnt;
        model_last_gnt = pred;
        exp_res = pred ? exp1 : exp0;
        checkOutput("cont_timing", cyc, 5 + 6 * n);
        checkOutput("cont_port", {ack1, ack0}, pred ? 2'b10 : 2'b01);
        checkOutput("cont_gnt_id", gnt_id, pred);
        checkOutput("cont_sum", sum, exp_res[7:0]);
        checkOutput("cont_cout", cout, exp_res[8]);
        if (pred) exp_acks1++; else exp_acks0++;
        n++;
        if (n == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
          break;
        end
      end
    end
    checkOutput("cont_ack_count", n, 4);
    @(negedge clk);

    // Reset during the second RUN cycle discards the operation.
    applyStimulus(0, 8'h77, 8'h11, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    checkOutput("abort_ack", {ack1, ack0}, 2'b00);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_cout", cout, 0);
    checkOutput("abort_gnt_id", gnt_id, 0);
    snap0 = ack_seen0;
    snap1 = ack_seen1;
    @(negedge clk);
    rst_n = 1'b1;
    model_last_gnt = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("abort_no_ack", (ack_seen0 - snap0) + (ack_seen1 - snap1), 0);
    doOp(0, 8'h12, 8'h34, 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) begin
      doOp(i[0], 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    @(negedge clk);
    checkOutput("ack0_total", ack_seen0, exp_acks0);
    checkOutput("ack1_total", ack_seen1, exp_acks1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
